// File: rtl/button_debounce.sv
// button_debounce
//
// Turns a raw, bouncing push-button pin into clean signals: a debounced
// level, one-cycle press/release pulses, and a long-press level plus pulse.
// The raw pin is brought into the clock domain with a 2-flop synchronizer.
// A change is accepted only after DEBOUNCE_CYCLES consecutive stable cycles.
//
// Parameters:
//   DEBOUNCE_CYCLES   - stable cycles needed to accept a change (>= 1)
//   LONG_CYCLES       - PRESSED cycles before long_press asserts (0 = off)
//   BUTTON_ACTIVE_LOW - 1 when the pin reads 0 while pressed
//
// Ports:
//   clk              in   system clock
//   reset            in   asynchronous, active-high reset
//   button_raw       in   raw pin, asynchronous to clk
//   button_level     out  debounced pressed state (1 = pressed)
//   press_pulse      out  one-cycle pulse on an accepted press
//   release_pulse    out  one-cycle pulse on an accepted release
//   long_press       out  high from long-press detection until release
//   long_press_pulse out  one-cycle pulse when long_press rises
module button_debounce #(
    parameter int DEBOUNCE_CYCLES   = 270000,
    parameter int LONG_CYCLES       = 27000000,
    parameter int BUTTON_ACTIVE_LOW = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic button_raw,
    output logic button_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press,
    output logic long_press_pulse
);

    localparam int DW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = (LONG_CYCLES < 1) ? 1 : $clog2(LONG_CYCLES + 1);

    localparam logic [DW-1:0] DLAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DMAX    = '1;
    // With LONG_CYCLES == 0 this value is meaningless; LONG_EN masks its use.
    localparam logic [HW-1:0] HLAST   = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HMAX    = '1;
    localparam logic          POL     = (BUTTON_ACTIVE_LOW != 0);
    localparam logic          LONG_EN = (LONG_CYCLES != 0);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_CHK,
        PRESSED,
        RELEASE_CHK
    } state_t;

    state_t        state, state_next;
    logic [DW-1:0] dcnt, dcnt_next;
    logic [HW-1:0] hcnt, hcnt_next;
    logic          sync1, sync2;
    logic          act;
    logic          level_next, long_next;
    logic          press_next, release_next, long_pulse_next;

    // Synchronizer: polarity is normalised on the way in so everything
    // downstream treats 1 as pressed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= button_raw ^ POL;
            sync2 <= sync1;
        end
    end

    assign act = sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= RELEASED;
            dcnt             <= '0;
            hcnt             <= '0;
            button_level     <= 1'b0;
            long_press       <= 1'b0;
            press_pulse      <= 1'b0;
            release_pulse    <= 1'b0;
            long_press_pulse <= 1'b0;
        end else begin
            state            <= state_next;
            dcnt             <= dcnt_next;
            hcnt             <= hcnt_next;
            button_level     <= level_next;
            long_press       <= long_next;
            press_pulse      <= press_next;
            release_pulse    <= release_next;
            long_press_pulse <= long_pulse_next;
        end
    end

    always_comb begin
        state_next      = state;
        dcnt_next       = dcnt;
        hcnt_next       = hcnt;
        level_next      = button_level;
        long_next       = long_press;
        press_next      = 1'b0;
        release_next    = 1'b0;
        long_pulse_next = 1'b0;

        case (state)
            RELEASED: begin
                dcnt_next = '0;
                if (act) begin
                    state_next = PRESS_CHK;
                end
            end

            PRESS_CHK: begin
                if (!act) begin
                    state_next = RELEASED;
                    dcnt_next  = '0;
                end else if (dcnt == DLAST) begin
                    state_next = PRESSED;
                    level_next = 1'b1;
                    press_next = 1'b1;
                    hcnt_next  = '0;
                end else if (dcnt != DMAX) begin
                    dcnt_next = dcnt + 1'b1;
                end
            end

            PRESSED: begin
                dcnt_next = '0;
                if (!act) begin
                    state_next = RELEASE_CHK;
                end else if (LONG_EN && !long_press && hcnt == HLAST) begin
                    long_next       = 1'b1;
                    long_pulse_next = 1'b1;
                end else if (!long_press && hcnt != HMAX) begin
                    hcnt_next = hcnt + 1'b1;
                end
            end

            RELEASE_CHK: begin
                // Returning to PRESSED keeps hcnt, so a release bounce only
                // pauses the long-press timer instead of restarting it.
                if (act) begin
                    state_next = PRESSED;
                end else if (dcnt == DLAST) begin
                    state_next   = RELEASED;
                    level_next   = 1'b0;
                    long_next    = 1'b0;
                    release_next = 1'b1;
                end else if (dcnt != DMAX) begin
                    dcnt_next = dcnt + 1'b1;
                end
            end

            default: begin
                state_next = RELEASED;
            end
        endcase
    end

endmodule
